// File: rtl/dvp_source_emu_pkg.sv
// Shared types for the DVP source emulator: FSM states and test-pattern selectors.
package dvp_emu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } state_t;

  localparam logic [1:0] MODE_HRAMP = 2'd0;
  localparam logic [1:0] MODE_VRAMP = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

endpackage

// File: rtl/dvp_source_emu_if.sv
// Camera-side DVP pin bundle; the emulator drives it, the capture path receives it.
interface dvp_source_emu_if;
  logic       O_pixclk;
  logic       O_vsync;
  logic       O_href;
  logic [9:0] O_pixdata;

  modport master (output O_pixclk, O_vsync, O_href, O_pixdata);
  modport slave  (input  O_pixclk, O_vsync, O_href, O_pixdata);
endinterface

// File: rtl/dvp_source_emu_pattern_gen.sv
// Combinational RAW10 test-pattern mapping from (mode, x, y, const) to one pixel.
module dvp_pattern_gen
  import dvp_emu_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic [9:0] const_i,
  output logic [9:0] pix_o
);

  always_comb begin
    pix_o = '0;
    case (mode_i)
      MODE_HRAMP: pix_o = x_i;
      MODE_VRAMP: pix_o = y_i;
      MODE_CHECK: pix_o = {10{x_i[3] ^ y_i[3]}};
      MODE_CONST: pix_o = const_i;
      default:    pix_o = '0;
    endcase
  end

endmodule

// File: rtl/dvp_source_emu.sv
// OV2640-style DVP transmitter: PIXCLK = I_clk/2, all video outputs change on the PIXCLK falling edge.
module dvp_source_emu
  import dvp_emu_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACTIVE = 480,
  parameter int VS_LINES = 3,
  parameter int V_BP     = 17,
  parameter int V_FP     = 10,
  parameter int CNT_W    = 12
) (
  input  logic              I_clk,
  input  logic              sys_resetn,
  input  logic              I_enable,
  input  logic [1:0]        I_mode,
  input  logic [9:0]        I_const,
  dvp_source_emu_if.master  dvp,
  output logic              O_frame_done,
  output logic [15:0]       O_frame_cnt
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_BLANK - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);

  if ((H_ACTIVE + H_BLANK) > (1 << CNT_W)) begin : g_cnt_w_chk
    $error("dvp_source_emu: line length does not fit in CNT_W");
  end

  state_t           state_q, state_d;
  logic             phase_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, vlast;
  logic [1:0]       mode_q, mode_d;
  logic [9:0]       const_q, const_d;
  logic             done_q, done_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             vsync_q, href_q, href_d;
  logic [9:0]       pix_q, pix_d;
  logic             line_end;

  // Last line index of the current state; the vertical counter restarts per state.
  always_comb begin
    vlast = CNT_W'(V_FP - 1);
    case (state_q)
      VSYNC:   vlast = CNT_W'(VS_LINES - 1);
      VBP:     vlast = CNT_W'(V_BP - 1);
      ACTIVE:  vlast = CNT_W'(V_ACTIVE - 1);
      default: vlast = CNT_W'(V_FP - 1);
    endcase
  end

  assign line_end = (hcnt_q == H_LAST);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    mode_d  = mode_q;
    const_d = const_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    if (phase_q) begin
      if (state_q == IDLE) begin
        if (I_enable) begin
          state_d = VSYNC;
          hcnt_d  = '0;
          vcnt_d  = '0;
          mode_d  = I_mode;
          const_d = I_const;
        end
      end else begin
        hcnt_d = line_end ? '0 : hcnt_q + CNT_W'(1);
        if (line_end) vcnt_d = (vcnt_q == vlast) ? '0 : vcnt_q + CNT_W'(1);
        if (line_end && (vcnt_q == vlast)) begin
          case (state_q)
            VSYNC:  state_d = VBP;
            VBP:    state_d = ACTIVE;
            ACTIVE: state_d = VFP;
            VFP: begin
              done_d = 1'b1;
              fcnt_d = fcnt_q + 16'd1;
              if (I_enable) begin
                state_d = VSYNC;
                mode_d  = I_mode;
                const_d = I_const;
              end else begin
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  // Outputs are registered from next-state so they only move on the tick edge.
  assign href_d = (state_d == ACTIVE) && (hcnt_d < H_ACT);

  logic [9:0] pat;
  dvp_pattern_gen u_pat (
    .mode_i  (mode_d),
    .x_i     (10'(hcnt_d)),
    .y_i     (10'(vcnt_d)),
    .const_i (const_d),
    .pix_o   (pat)
  );

  assign pix_d = href_d ? pat : '0;

  always_ff @(posedge I_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      phase_q <= 1'b0;
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      mode_q  <= '0;
      const_q <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      phase_q <= ~phase_q;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      mode_q  <= mode_d;
      const_q <= const_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      vsync_q <= (state_d == VSYNC);
      href_q  <= href_d;
      pix_q   <= pix_d;
    end
  end

  assign dvp.O_pixclk  = phase_q;
  assign dvp.O_vsync   = vsync_q;
  assign dvp.O_href    = href_q;
  assign dvp.O_pixdata = pix_q;
  assign O_frame_done  = done_q;
  assign O_frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_dvp_source_emu.sv
// Bench for dvp_source_emu: frame-level tick model checked every cycle plus directed literal checks.
module tb_dvp_source_emu;

  localparam int HA = 8, HB = 4, VA = 4, VSL = 1, VBPL = 2, VFPL = 1;
  localparam int L = HA + HB;
  localparam int FRAME = (VSL + VBPL + VA + VFPL) * L;

  logic        I_clk = 1'b0;
  logic        sys_resetn = 1'b1;
  logic        I_enable = 1'b0;
  logic [1:0]  I_mode = 2'd0;
  logic [9:0]  I_const = 10'd0;
  logic        O_frame_done;
  logic [15:0] O_frame_cnt;

  dvp_source_emu_if dvp();

  dvp_source_emu #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VS_LINES(VSL), .V_BP(VBPL), .V_FP(VFPL), .CNT_W(12)
  ) dut (
    .I_clk        (I_clk),
    .sys_resetn   (sys_resetn),
    .I_enable     (I_enable),
    .I_mode       (I_mode),
    .I_const      (I_const),
    .dvp          (dvp),
    .O_frame_done (O_frame_done),
    .O_frame_cnt  (O_frame_cnt)
  );

  always #5 I_clk = ~I_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge I_clk) cyc <= cyc + 1;

  // Frame-level model: position within the frame is just a tick count.
  logic        m_phase, m_run, m_done;
  int          m_t;
  logic [1:0]  m_mode;
  logic [9:0]  m_const;
  logic [15:0] m_cnt;

  always @(posedge I_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      m_phase <= 1'b0; m_run <= 1'b0; m_done <= 1'b0; m_t <= 0;
      m_mode <= 2'd0; m_const <= 10'd0; m_cnt <= 16'd0;
    end else begin
      m_phase <= ~m_phase;
      m_done  <= 1'b0;
      if (m_phase) begin
        if (!m_run) begin
          if (I_enable) begin
            m_run <= 1'b1; m_t <= 0; m_mode <= I_mode; m_const <= I_const;
          end
        end else if (m_t == FRAME - 1) begin
          m_done <= 1'b1;
          m_cnt  <= m_cnt + 16'd1;
          if (I_enable) begin
            m_t <= 0; m_mode <= I_mode; m_const <= I_const;
          end else begin
            m_run <= 1'b0;
          end
        end else begin
          m_t <= m_t + 1;
        end
      end
    end
  end

  always @(negedge I_clk) begin
    int line, h, y;
    logic ev, eh;
    logic [9:0] ep;
    ev = 1'b0; eh = 1'b0; ep = 10'd0;
    if (m_run) begin
      line = m_t / L;
      h    = m_t % L;
      y    = line - VSL - VBPL;
      ev   = (line < VSL);
      eh   = (y >= 0) && (y < VA) && (h < HA);
      if (eh) begin
        case (m_mode)
          2'd0: ep = 10'(h);
          2'd1: ep = 10'(y);
          2'd2: ep = (((h / 8) + (y / 8)) % 2 == 1) ? 10'h3FF : 10'h000;
          default: ep = m_const;
        endcase
      end
    end
    chk("pixclk", 32'(dvp.O_pixclk), 32'(m_phase));
    chk("vsync", 32'(dvp.O_vsync), 32'(ev));
    chk("href", 32'(dvp.O_href), 32'(eh));
    chk("pixdata", 32'(dvp.O_pixdata), 32'(ep));
    chk("frame_done", 32'(O_frame_done), 32'(m_done));
    chk("frame_cnt", 32'(O_frame_cnt), 32'(m_cnt));
  end

  // Pixels as the receiver would see them: sampled on the PIXCLK rising edge.
  logic [9:0] px_q[$];
  always @(posedge dvp.O_pixclk) if (dvp.O_href) px_q.push_back(dvp.O_pixdata);

  int done_cyc = 0;
  int done_cnt = 0;

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!O_frame_done && n < 500) begin
      @(negedge I_clk);
      n++;
    end
    chk(name, 32'(O_frame_done), 32'd1);
    done_cyc = cyc;
    done_cnt = int'(O_frame_cnt);
    @(negedge I_clk);
  endtask

  // kind: 0 x-ramp, 1 line index, 2 all zero (checker, x,y < 8), 3 constant 0x2A5
  task automatic chk_frame(input string name, input int kind);
    int e;
    chk({name, "_len"}, 32'(px_q.size()), 32'd32);
    for (int i = 0; i < px_q.size() && i < 32; i++) begin
      case (kind)
        0: e = i % 8;
        1: e = i / 8;
        2: e = 0;
        default: e = 'h2A5;
      endcase
      chk(name, 32'(px_q[i]), 32'(e));
    end
    px_q.delete();
  endtask

  initial begin
    int c0, n, rises;
    logic prev;
    #1 sys_resetn = 1'b0;
    repeat (3) @(negedge I_clk);
    chk("rst_pixclk", 32'(dvp.O_pixclk), 0);
    chk("rst_vsync", 32'(dvp.O_vsync), 0);
    chk("rst_href", 32'(dvp.O_href), 0);
    chk("rst_pixdata", 32'(dvp.O_pixdata), 0);
    chk("rst_done", 32'(O_frame_done), 0);
    chk("rst_cnt", 32'(O_frame_cnt), 0);

    px_q.delete();
    sys_resetn = 1'b1;
    I_enable = 1'b1;
    I_mode = 2'd0;

    n = 0;
    while (!dvp.O_vsync && n < 50) begin @(negedge I_clk); n++; end
    chk("vsync_start", 32'(dvp.O_vsync), 1);
    c0 = cyc;
    n = 0;
    while (dvp.O_vsync && n < 1000) begin @(negedge I_clk); n++; end
    chk("vsync_ticks", 32'(n / 2), 32'd12);
    n = 0;
    while (!dvp.O_href && n < 500) begin @(negedge I_clk); n++; end
    chk("href_delay_ticks", 32'((cyc - c0) / 2), 32'd36);

    wait_done("done1");
    chk("cnt1", 32'(done_cnt), 1);
    chk_frame("f1_hramp", 0);
    c0 = done_cyc;
    I_mode = 2'd2;

    wait_done("done2");
    chk("period", 32'(done_cyc - c0), 32'd192);
    chk("cnt2", 32'(done_cnt), 2);
    chk_frame("f2_hramp", 0);
    I_mode = 2'd3;
    I_const = 10'h2A5;

    wait_done("done3");
    chk("cnt3", 32'(done_cnt), 3);
    chk_frame("f3_check", 2);
    I_mode = 2'd0;

    wait_done("done4");
    chk_frame("f4_const", 3);

    rises = 0; prev = dvp.O_href; n = 0;
    while (rises < 3 && n < 400) begin
      @(negedge I_clk);
      if (dvp.O_href && !prev) rises++;
      prev = dvp.O_href;
      n++;
    end
    chk("reach_line2", 32'(rises), 3);
    I_mode = 2'd1;
    wait_done("done5");
    chk_frame("f5_hramp", 0);
    wait_done("done6");
    chk_frame("f6_vramp", 1);

    repeat (1500) begin
      @(negedge I_clk);
      if ($urandom_range(49) == 0) begin
        I_mode = 2'($urandom_range(3));
        I_const = 10'($urandom);
      end
      if ($urandom_range(199) == 0) I_enable = ~I_enable;
    end

    I_enable = 1'b1;
    I_mode = 2'd0;
    prev = dvp.O_vsync; n = 0;
    while (!(dvp.O_vsync && !prev) && n < 500) begin
      prev = dvp.O_vsync;
      @(negedge I_clk);
      n++;
    end
    chk("vsync_rise", 32'(dvp.O_vsync), 1);
    px_q.delete();
    n = 0;
    while (dvp.O_vsync && n < 100) begin @(negedge I_clk); n++; end
    I_enable = 1'b0;
    wait_done("done_en_drop");
    chk_frame("fdrop_hramp", 0);
    repeat (200) @(negedge I_clk);
    chk("idle_vsync", 32'(dvp.O_vsync), 0);
    chk("idle_href", 32'(dvp.O_href), 0);
    chk("idle_pixdata", 32'(dvp.O_pixdata), 0);
    chk("idle_px_none", 32'(px_q.size()), 0);

    I_enable = 1'b1;
    n = 0;
    while (!dvp.O_href && n < 500) begin @(negedge I_clk); n++; end
    chk("href_before_rst", 32'(dvp.O_href), 1);
    repeat (3) @(negedge I_clk);
    #2 sys_resetn = 1'b0;
    #1;
    chk("arst_pixclk", 32'(dvp.O_pixclk), 0);
    chk("arst_vsync", 32'(dvp.O_vsync), 0);
    chk("arst_href", 32'(dvp.O_href), 0);
    chk("arst_pixdata", 32'(dvp.O_pixdata), 0);
    chk("arst_done", 32'(O_frame_done), 0);
    chk("arst_cnt", 32'(O_frame_cnt), 0);
    @(negedge I_clk);
    px_q.delete();
    sys_resetn = 1'b1;
    wait_done("done_after_rst");
    chk("cnt_after_rst", 32'(done_cnt), 1);
    chk_frame("frst_hramp", 0);

    repeat (4) @(negedge I_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvp_source_emu.md
Name: dvp_source_emu

Overview:
- Synthesizable DVP camera-side transmitter that emulates the OV2640 parallel output: PIXCLK, VSYNC, HREF and PIXDATA[9:0] in RAW10.
- Generates deterministic frames from I_clk, so the camera capture path and frame-buffer write path can be exercised in simulation and on the board without a sensor.
- Sits between the top-level clocking/reset and the capture mux, in the position the sensor pins occupy.

Parameters:
- H_ACTIVE, 640, pixels per line with HREF high
- H_BLANK, 144, pixel periods per line with HREF low
- V_ACTIVE, 480, active lines per frame
- VS_LINES, 3, lines with VSYNC high
- V_BP, 17, blank lines after VSYNC before the first active line
- V_FP, 10, blank lines after the last active line
- CNT_W, 12, width of the horizontal and vertical counters

Ports:
- I_clk  input  1  system clock, 27 MHz
- sys_resetn  input  1  asynchronous active-low reset
- I_enable  input  1  level; run frames while high
- I_mode  input  2  pattern: 0 horizontal ramp, 1 vertical ramp, 2 checker, 3 constant
- I_const  input  10  value used in mode 3
- O_pixclk  output  1  emulated PIXCLK, I_clk/2
- O_vsync  output  1  VSYNC, active high
- O_href  output  1  HREF, active high
- O_pixdata  output  10  RAW10 pixel data
- O_frame_done  output  1  one-I_clk pulse at the end of each frame
- O_frame_cnt  output  16  completed frames, wraps from 0xFFFF to 0

Behaviour:
Interface decision: reset sys_resetn, asynchronous, active-low; clock I_clk.

Reset:
- All outputs are 0, including O_pixclk.
- FSM is in IDLE; counters are 0.

Pixel timing:
- Register phase toggles every I_clk cycle; O_pixclk = phase.
- Tick = the cycle where phase==1.
- All of VSYNC, HREF, PIXDATA and the counters update only on a tick, which is the falling edge of O_pixclk.
- The receiver samples on the rising edge of O_pixclk, so data is stable for 1 I_clk cycle either side of that edge.

Counters and frame length:
- Line length L = H_ACTIVE + H_BLANK ticks.
- hcnt counts 0..L-1; vcnt counts lines within the current FSM state.
- Frame = (VS_LINES + V_BP + V_ACTIVE + V_FP) × L ticks.

FSM (transitions on ticks only):
- IDLE: outputs low. Go to VSYNC on a tick with I_enable==1. Latch I_mode and I_const on that tick. VSYNC goes high on that same tick.
- VSYNC: O_vsync=1, O_href=0 for VS_LINES lines, then go to VBP.
- VBP: all low for V_BP lines, then go to ACTIVE.
- ACTIVE: per line, O_href=1 with valid data for hcnt 0..H_ACTIVE-1, then O_href=0 and O_pixdata=0 for H_BLANK ticks. After V_ACTIVE lines, go to VFP.
- VFP: all low for V_FP lines. At the last tick, pulse O_frame_done for 1 I_clk cycle and increment O_frame_cnt.
- Leaving VFP: go to VSYNC if I_enable==1 (and re-latch mode/const), otherwise go to IDLE.

Enable and mode handling:
- I_enable going low mid-frame never truncates the frame. The current frame always completes.
- I_mode and I_const changes mid-frame are ignored until the next frame start.

Patterns (x = hcnt, y = active line index, both truncated to 10 bits):
- mode 0: x
- mode 1: y
- mode 2: {10{x[3]^y[3]}}
- mode 3: latched I_const
- O_pixdata is 0 whenever O_href==0.

Boundary conditions:
- The counters must not overflow; H_ACTIVE + H_BLANK must be ≤ 2^CNT_W.
- Reset asserted mid-line forces IDLE immediately and all outputs to 0. There is no partial frame-done pulse.

Decomposition:
- Package dvp_emu_pkg holds:
  - state enum: IDLE, VSYNC, VBP, ACTIVE, VFP
  - mode constants: MODE_HRAMP=0, MODE_VRAMP=1, MODE_CHECK=2, MODE_CONST=3
- One sub-module, dvp_pattern_gen: combinational mapping of (mode, x, y, const) to the 10-bit pixel.
- Timing counters and the FSM live in dvp_source_emu.

Test Plan (bench params: H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VS_LINES=1, V_BP=2, V_FP=1; L=12 ticks, frame=96 ticks=192 I_clk):
1. Reset then I_enable=1 held: O_pixclk toggles every cycle; VSYNC high exactly 12 ticks; first HREF rises 36 ticks after VSYNC rises; O_frame_done pulses every 192 I_clk; O_frame_cnt counts 1,2,3.
2. Mode 0: each active line carries PIXDATA 0,1,...,7 with HREF high 8 ticks, then 4 ticks of 0 with HREF low. Every value is stable on each O_pixclk rising edge.
3. Mode 2, and mode 3 with I_const=0x2A5: checker outputs 0x000 for x 0..7 on all lines (x[3]=0, y[3]=0); constant mode outputs 0x2A5 on all 32 active pixels.
4. Change I_mode from 0 to 1 during ACTIVE line 2: the current frame stays a ramp in x; the next frame outputs the line index 0..3.
5. Drop I_enable during VBP: the frame completes all 4 active lines, O_frame_done pulses, then the FSM enters IDLE with all outputs low.
6. Assert sys_resetn low mid-ACTIVE: outputs go to 0 asynchronously and O_frame_cnt=0. After release with I_enable=1, a full, correct frame restarts from VSYNC.
